// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature encoder emulator: default widths,
// the (A,B) phase encoding with its step functions, and direction codes.
package quad_pkg;

  localparam int POS_W_DEFAULT = 10;
  localparam int DIV_W_DEFAULT = 16;

  // Encoding is the literal (A,B) pair, so A = phase[1] and B = phase[0].
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_10 = 2'b10,
    PH_11 = 2'b11
  } phase_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  function automatic phase_t phase_fwd(input phase_t ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  function automatic phase_t phase_rev(input phase_t ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_encoder_emulator_step_tick_gen.sv
// Step-rate prescaler: emits a one-cycle tick every max(step_div,1) enabled
// cycles; hold freezes the count, clear parks it at zero.
module step_tick_gen
  import quad_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             clear,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] max_m1;

  assign max_m1 = (step_div == '0) ? '0 : step_div - DIV_W'(1);

  // ">=" rather than "==" so a shrinking step_div fires at once instead of
  // letting the counter run all the way around.
  assign tick = !hold && !clear && (cnt_reg >= max_m1);

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (!hold) begin
      cnt_next = tick ? '0 : cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature transmitter walking a virtual shaft (mod ppr, shortest path)
// toward a target. Optional Z index output enabled by QUAD_EMU_INDEX_EN.
module quad_encoder_emulator
  import quad_pkg::*;
#(
  parameter int POS_W = POS_W_DEFAULT,
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [POS_W-1:0] ppr,
  input  logic [POS_W-1:0] target,
  input  logic [DIV_W-1:0] step_div,
  output logic             A,
  output logic             B,
  output logic             Z,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             dir
);

  phase_t           phase_reg;
  phase_t           phase_next;
  logic [POS_W-1:0] pos_reg;
  logic [POS_W-1:0] pos_next;
  logic             dir_reg;
  logic             dir_next;
  logic             busy_reg;
  logic             busy_next;

  logic             hold_mode;
  logic             pos_oob;
  logic [POS_W-1:0] tgt_eff;
  logic [POS_W-1:0] diff;
  logic             diff_nz;
  logic             go_fwd;
  logic             tick;
  logic             step_ok;

  step_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .hold    (!en),
    .clear   (!busy_reg),
    .step_div(step_div),
    .tick    (tick)
  );

  assign hold_mode = (ppr < POS_W'(4));
  assign pos_oob   = (pos_reg >= ppr);
  assign tgt_eff   = (target < ppr) ? target : ppr - POS_W'(1);

  // Modular distance kept in POS_W bits: both branches stay below ppr.
  always_comb begin
    if (tgt_eff >= pos_reg) begin
      diff = tgt_eff - pos_reg;
    end else begin
      diff = tgt_eff + (ppr - pos_reg);
    end
  end

  assign diff_nz = !hold_mode && !pos_oob && (diff != '0);
  assign go_fwd  = (diff <= (ppr >> 1));
  assign step_ok = tick && diff_nz;

  always_comb begin
    phase_next = phase_reg;
    pos_next   = pos_reg;
    dir_next   = dir_reg;
    busy_next  = diff_nz;
    if (pos_oob) begin
      pos_next = '0;
    end else if (step_ok) begin
      if (go_fwd) begin
        phase_next = phase_fwd(phase_reg);
        pos_next   = (pos_reg == ppr - POS_W'(1)) ? '0 : pos_reg + POS_W'(1);
        dir_next   = DIR_FWD;
      end else begin
        phase_next = phase_rev(phase_reg);
        pos_next   = (pos_reg == '0) ? ppr - POS_W'(1) : pos_reg - POS_W'(1);
        dir_next   = DIR_REV;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_reg <= PH_00;
      pos_reg   <= '0;
      dir_reg   <= DIR_FWD;
      busy_reg  <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      pos_reg   <= pos_next;
      dir_reg   <= dir_next;
      busy_reg  <= busy_next;
    end
  end

`ifdef QUAD_EMU_INDEX_EN
  logic z_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_reg <= 1'b0;
    end else begin
      z_reg <= (pos_next == '0) && (phase_next == PH_00);
    end
  end

  assign Z = z_reg;
`else
  assign Z = 1'b0;
`endif

  assign A        = phase_reg[1];
  assign B        = phase_reg[0];
  assign position = pos_reg;
  assign busy     = busy_reg;
  assign dir      = dir_reg;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench: directed moves from the test plan plus random moves,
// judged against a shortest-path position/phase model.
module tb_quad_encoder_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [9:0]  ppr;
  logic [9:0]  target;
  logic [15:0] step_div;
  logic        A, B, Z, busy, dir;
  logic [9:0]  position;

  int n_checks = 0;
  int n_pass   = 0;
  int m_pos    = 0;  // model shaft count
  int m_q      = 0;  // model quarter-cycle index into seq

  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always #5 clk = ~clk;

  quad_encoder_emulator #(.POS_W(10), .DIV_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .ppr     (ppr),
    .target  (target),
    .step_div(step_div),
    .A       (A),
    .B       (B),
    .Z       (Z),
    .position(position),
    .busy    (busy),
    .dir     (dir)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int z_wrong();
`ifdef QUAD_EMU_INDEX_EN
    return (Z != ((position == 10'd0) && !A && !B)) ? 1 : 0;
`else
    return (Z != 1'b0) ? 1 : 0;
`endif
  endfunction

  // Drive a new (ppr, step_div, target) at a negedge, follow every edge
  // against the model, optionally freezing after freeze_at steps.
  task automatic run_move(input int p, input int sd, input int tgt, input int freeze_at);
    int te, d, steps, seen, gap, budget, cyc, zbad, holdbad, per;
    bit fwd, frz_ok;
    logic [1:0] prev_ab, ab;
    per = (sd == 0) ? 1 : sd;
    if (m_pos >= p) m_pos = 0;
    fwd = 1'b1;
    steps = 0;
    if (p >= 4) begin
      te = (tgt < p) ? tgt : p - 1;
      d = ((te - m_pos) % p + p) % p;
      fwd = (d != 0) && (d <= p / 2);
      steps = (d == 0) ? 0 : (fwd ? d : p - d);
    end
    ppr = 10'(p);
    step_div = 16'(sd);
    target = 10'(tgt);
    prev_ab = {A, B};
    seen = 0; gap = 0; zbad = 0; holdbad = 0; cyc = 0;
    budget = (steps + 2) * per + 10;
    while (seen < steps && cyc < budget) begin
      @(negedge clk);
      cyc++;
      gap++;
      ab = {A, B};
      zbad += z_wrong();
      if (ab != prev_ab) begin
        seen++;
        m_q = fwd ? (m_q + 1) % 4 : (m_q + 3) % 4;
        m_pos = fwd ? (m_pos + 1) % p : (m_pos + p - 1) % p;
        check("ab", ab, seq[m_q]);
        check("pos", position, m_pos);
        if (seen > 1) check("gap", gap, per);
        gap = 0;
        prev_ab = ab;
        if (seen == freeze_at) begin
          en = 1'b0;
          frz_ok = 1'b1;
          repeat (50) begin
            @(negedge clk);
            if ({A, B} != ab || position != 10'(m_pos) || busy !== 1'b1) frz_ok = 1'b0;
          end
          check("freeze", frz_ok, 1);
          en = 1'b1;
        end
      end else if (position != 10'(m_pos)) begin
        holdbad++;
      end
    end
    check("steps", seen, steps);
    if (steps > 0) begin
      check("busy_last", busy, 1);
      check("dir", dir, fwd);
    end
    @(negedge clk);
    check("busy_idle", busy, 0);
    repeat (per + 3) begin
      @(negedge clk);
      if ({A, B} != prev_ab || position != 10'(m_pos)) holdbad++;
      zbad += z_wrong();
    end
    check("hold", holdbad, 0);
    check("z", zbad, 0);
    $display("move ppr=%0d div=%0d tgt=%0d steps=%0d pos=%0d", p, sd, tgt, seen, position);
  endtask

  initial begin
    int p, sd, tgt;
    reset = 1'b0;
    en = 1'b1;
    ppr = 10'd600;
    step_div = 16'd4;
    target = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_a", A, 0);
    check("rst_b", B, 0);
    check("rst_z", Z, 0);
    check("rst_pos", position, 0);
    check("rst_busy", busy, 0);
    check("rst_dir", dir, 1);
    reset = 1'b1;

    run_move(600, 4, 5, -1);     // forward from reset
    run_move(600, 1, 2, -1);
    run_move(600, 2, 598, -1);   // reverse through 0
    run_move(64, 1, 0, -1);      // ppr shrink forces position to 0
    run_move(64, 1, 32, -1);     // tie goes forward
    run_move(64, 1, 900, -1);    // clamp to 63
    run_move(600, 3, m_pos + 10, 4);
    run_move(600, 1, 500, -1);
    run_move(256, 2, 0, -1);     // position 500 -> 0, no edge
    check("shrink_pos", position, 0);
    run_move(256, 0, 3, -1);     // step_div 0: one step per clk
    run_move(3, 1, 1, -1);       // ppr < 4 holds
    run_move(600, 1, 590, -1);
    run_move(600, 1, 8, -1);     // forward sweep over index

    p = 600;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) != 0) p = $urandom_range(4, 300);
      sd = $urandom_range(0, 3);
      tgt = $urandom_range(0, 1023);
      run_move(p, sd, tgt, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
